// File: rtl/rr_grant_encoder_pkg.sv
// Shared types and helpers for the round-robin grant encoder.
package rr_pkg;

  localparam int unsigned RR_N  = 4;
  localparam int unsigned RR_IW = $clog2(RR_N);

  typedef enum logic {
    IDLE,
    HOLD
  } rr_state_e;

  // One-hot expansion of a requester index at the default width.
  function automatic logic [RR_N-1:0] rr_onehot(input logic [RR_IW-1:0] idx);
    logic [RR_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_grant_encoder_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
  import rr_pkg::*;
#(
  parameter int unsigned N  = RR_N,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any_req
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  enc;
  logic           found;

  // Rotate so ptr lands at bit 0, priority-encode the lowest set bit, rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    enc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        enc   = IW'(i);
        found = 1'b1;
      end
    end
    pick    = enc + ptr;
    any_req = |req;
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Registered round-robin request encoder: holds one grant until acked.
module rr_grant_encoder
  import rr_pkg::*;
#(
  parameter  int unsigned N  = RR_N,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          e,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  grant,
  output logic          valid
);

  rr_state_e     state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;

  logic [IW-1:0] scan_ptr;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          retire;

  assign retire = (state_q == HOLD) && ack;

  // An ack advances the pointer past the served index before rescanning, so the
  // picker sees the updated pointer in the same cycle for back-to-back grants.
  always_comb begin
    scan_ptr = retire ? idx_q + IW'(1) : ptr_q;
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (scan_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (e && any_req) begin
          idx_d       = pick;
          grant_d     = '0;
          grant_d[pick] = 1'b1;
          valid_d     = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          ptr_d = scan_ptr;
          if (e && any_req) begin
            idx_d         = pick;
            grant_d       = '0;
            grant_d[pick] = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign idx   = idx_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder; outputs compared as {valid, idx, grant}.
module tb_rr_grant_encoder;
  import rr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       e;
  logic [3:0] req;
  logic       ack;
  logic [1:0] idx;
  logic [3:0] grant;
  logic       valid;

  int unsigned tests = 0;
  int unsigned fails = 0;

  rr_grant_encoder #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .e     (e),
    .req   (req),
    .ack   (ack),
    .idx   (idx),
    .grant (grant),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; e = 1'b0; req = '0; ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    reset = 1'b1; e = 1'b1; req = 4'b1111; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp = {1'b0, 2'd0, 4'b0000};
      tests++;
      if ({valid, idx, grant} !== exp) begin
        fails++;
        $display("FAIL reset_hold cyc%0d got=%b exp=%b", c, {valid, idx, grant}, exp);
      end
    end
    reset = 1'b0;
    tick();
    exp = {1'b1, 2'd0, 4'b0001};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL reset_first_grant got=%b exp=%b", {valid, idx, grant}, exp);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] seq [5];
    logic [6:0] exp;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    e = 1'b1; req = 4'b1111; ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp = {1'b1, seq[c], rr_onehot(seq[c])};
      tests++;
      if ({valid, idx, grant} !== exp) begin
        fails++;
        $display("FAIL rotation step%0d got=%b exp=%b", c, {valid, idx, grant}, exp);
      end
    end
    ack = 1'b0; req = '0;
  endtask

  task automatic test_wrap_skip();
    logic [6:0] exp;
    do_reset();
    e = 1'b1; req = 4'b0100; ack = 1'b0;
    tick();
    req = 4'b0101; ack = 1'b1;
    tick();
    exp = {1'b1, 2'd0, 4'b0001};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL wrap_to_0 got=%b exp=%b", {valid, idx, grant}, exp);
    end
    tick();
    exp = {1'b1, 2'd2, 4'b0100};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL skip_to_2 got=%b exp=%b", {valid, idx, grant}, exp);
    end
    req = '0;
    tick();
    exp = {1'b0, 2'd2, 4'b0000};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL retire_keeps_idx got=%b exp=%b", {valid, idx, grant}, exp);
    end
    ack = 1'b0;
  endtask

  task automatic test_hold_no_ack();
    logic [6:0] exp;
    do_reset();
    e = 1'b1; req = 4'b0010; ack = 1'b0;
    tick();
    req = '0; e = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp = {1'b1, 2'd1, 4'b0010};
      tests++;
      if ({valid, idx, grant} !== exp) begin
        fails++;
        $display("FAIL hold_no_ack cyc%0d got=%b exp=%b", c, {valid, idx, grant}, exp);
      end
    end
    e = 1'b1; ack = 1'b1;
    tick();
    exp = {1'b0, 2'd1, 4'b0000};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL hold_release got=%b exp=%b", {valid, idx, grant}, exp);
    end
    ack = 1'b0;
  endtask

  task automatic test_enable();
    logic [6:0] exp;
    do_reset();
    e = 1'b0; req = 4'b0010; ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp = {1'b0, 2'd0, 4'b0000};
      tests++;
      if ({valid, idx, grant} !== exp) begin
        fails++;
        $display("FAIL enable_gated cyc%0d got=%b exp=%b", c, {valid, idx, grant}, exp);
      end
    end
    // ack while idle must not move the pointer: all-ones request still picks 0.
    ack = 1'b0; req = 4'b1111; e = 1'b1;
    tick();
    exp = {1'b1, 2'd0, 4'b0001};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL idle_ack_ignored got=%b exp=%b", {valid, idx, grant}, exp);
    end
    do_reset();
    e = 1'b0; req = 4'b0010;
    tick();
    e = 1'b1;
    tick();
    exp = {1'b1, 2'd1, 4'b0010};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL enable_raise got=%b exp=%b", {valid, idx, grant}, exp);
    end
    // Ack with e low retires the grant even though requests remain.
    e = 1'b0; ack = 1'b1; req = 4'b1111;
    tick();
    exp = {1'b0, 2'd1, 4'b0000};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL ack_with_e0 got=%b exp=%b", {valid, idx, grant}, exp);
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    logic [6:0] exp;
    do_reset();
    e = 1'b1; req = 4'b0100; ack = 1'b0;
    tick();
    reset = 1'b1; ack = 1'b1; req = 4'b1111;
    tick();
    exp = {1'b0, 2'd0, 4'b0000};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL reset_mid_hold got=%b exp=%b", {valid, idx, grant}, exp);
    end
    reset = 1'b0; ack = 1'b0; req = 4'b1100;
    tick();
    exp = {1'b1, 2'd2, 4'b0100};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL reset_ptr_cleared got=%b exp=%b", {valid, idx, grant}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    logic [6:0] exp;
    seq = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    e = 1'b1; req = 4'b1010; ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp = {1'b1, seq[c], rr_onehot(seq[c])};
      tests++;
      if ({valid, idx, grant} !== exp) begin
        fails++;
        $display("FAIL back_to_back step%0d got=%b exp=%b", c, {valid, idx, grant}, exp);
      end
    end
    // Lone requester after its ack is re-granted.
    req = 4'b1000;
    tick();
    exp = {1'b1, 2'd3, 4'b1000};
    tests++;
    if ({valid, idx, grant} !== exp) begin
      fails++;
      $display("FAIL sole_regrant got=%b exp=%b", {valid, idx, grant}, exp);
    end
    ack = 1'b0; req = '0;
  endtask

  initial begin
    reset = 1'b1; e = 1'b0; req = '0; ack = 1'b0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold_no_ack();
    test_enable();
    test_reset_mid_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
